// File: rtl/retire_stage.sv
// Two-lane retire stage: ALU rows write the register file and free their preg next cycle;
// store rows queue in a small FIFO that a three-state FSM drains to memory one store at a time.
module retire_stage #(
   parameter int PREG_W   = 6,
   parameter int SQ_DEPTH = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_ret_valid    [0:1],
   input  logic              i_ret_regwrite [0:1],
   input  logic              i_ret_memwrite [0:1],
   input  logic [PREG_W-1:0] i_ret_dst      [0:1],
   input  logic [31:0]       i_ret_data     [0:1],
   output logic              o_ret_ready,
   output logic              o_w_en         [0:1],
   output logic [PREG_W-1:0] o_w_addr       [0:1],
   output logic [31:0]       o_w_data       [0:1],
   output logic              o_free_valid   [0:1],
   output logic [PREG_W-1:0] o_free_preg    [0:1],
   output logic [PREG_W-1:0] o_r_addr,
   input  logic [31:0]       i_r_data,
   output logic              o_mem_en,
   output logic [31:0]       o_mem_addr,
   output logic [31:0]       o_mem_data,
   output logic              o_sq_empty,
   output logic [31:0]       o_retired_cnt
);

   localparam int PTR_W = (SQ_DEPTH > 1) ? $clog2(SQ_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;

   logic [31:0]       sq_addr [SQ_DEPTH];
   logic [PREG_W-1:0] sq_preg [SQ_DEPTH];

   logic [PTR_W-1:0]  head_reg;
   logic [PTR_W-1:0]  tail_reg;
   logic [PTR_W-1:0]  tail_hi;
   logic [PTR_W-1:0]  head_inc;
   logic [CNT_W-1:0]  count_reg;
   logic [CNT_W-1:0]  count_next;
   logic [CNT_W-1:0]  push_cnt;

   logic [1:0]        state_reg;
   logic [1:0]        state_next;
   logic              rd_wait_reg;
   logic              rd_wait_next;
   logic [31:0]       data_reg;
   logic [31:0]       data_next;
   logic [PREG_W-1:0] r_addr_next;
   logic              pop;

   logic              lane_acc   [0:1];
   logic              lane_store [0:1];
   logic              lane_alu   [0:1];

   // Two free slots are always reserved so a pair of stores can never overflow.
   assign o_ret_ready = (count_reg <= CNT_W'(SQ_DEPTH - 2));

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_lane
         assign lane_acc[gi]   = o_ret_ready & i_ret_valid[gi];
         assign lane_store[gi] = lane_acc[gi] & i_ret_memwrite[gi];
         assign lane_alu[gi]   = lane_acc[gi] & i_ret_regwrite[gi] & ~i_ret_memwrite[gi];
      end
   endgenerate

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int l = 0; l < 2; l++) begin
            o_w_en[l]       <= 1'b0;
            o_w_addr[l]     <= '0;
            o_w_data[l]     <= '0;
            o_free_valid[l] <= 1'b0;
            o_free_preg[l]  <= '0;
         end
         o_retired_cnt <= '0;
      end else begin
         for (int l = 0; l < 2; l++) begin
            o_w_en[l]       <= lane_alu[l];
            o_free_valid[l] <= lane_alu[l];
            if (lane_alu[l]) begin
               o_w_addr[l]    <= i_ret_dst[l];
               o_w_data[l]    <= i_ret_data[l];
               o_free_preg[l] <= i_ret_dst[l];
            end
         end
         o_retired_cnt <= o_retired_cnt + 32'(lane_acc[0]) + 32'(lane_acc[1]);
      end
   end

   // Lane 0 takes the tail slot, so it is older in the queue and drains first.
   assign tail_hi  = tail_reg + PTR_W'(lane_store[0]);
   assign head_inc = head_reg + PTR_W'(1);
   assign push_cnt = CNT_W'(lane_store[0]) + CNT_W'(lane_store[1]);
   assign count_next = count_reg + push_cnt - CNT_W'(pop);

   always_ff @(posedge i_clk) begin
      if (lane_store[0]) begin
         sq_addr[tail_reg] <= i_ret_data[0];
         sq_preg[tail_reg] <= i_ret_dst[0];
      end
      if (lane_store[1]) begin
         sq_addr[tail_hi] <= i_ret_data[1];
         sq_preg[tail_hi] <= i_ret_dst[1];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         tail_reg  <= tail_reg + PTR_W'(push_cnt);
         head_reg  <= pop ? head_inc : head_reg;
         count_reg <= count_next;
      end
   end

   // READ dwells two cycles because the register file answers one cycle after o_r_addr moves.
   // Leaving WRITE only looks at entries already queued, so a store pushed this cycle waits
   // in IDLE one cycle and its same-cycle register write has landed before it is read.
   always_comb begin
      state_next   = state_reg;
      rd_wait_next = rd_wait_reg;
      data_next    = data_reg;
      r_addr_next  = o_r_addr;
      pop          = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (count_reg != '0) begin
               state_next   = ST_READ;
               rd_wait_next = 1'b0;
               r_addr_next  = sq_preg[head_reg];
            end
         end
         ST_READ: begin
            if (!rd_wait_reg) begin
               rd_wait_next = 1'b1;
            end else begin
               data_next    = i_r_data;
               rd_wait_next = 1'b0;
               state_next   = ST_WRITE;
            end
         end
         ST_WRITE: begin
            pop = 1'b1;
            if (count_reg > CNT_W'(1)) begin
               state_next  = ST_READ;
               r_addr_next = sq_preg[head_inc];
            end else begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg   <= ST_IDLE;
         rd_wait_reg <= 1'b0;
         data_reg    <= '0;
         o_r_addr    <= '0;
      end else begin
         state_reg   <= state_next;
         rd_wait_reg <= rd_wait_next;
         data_reg    <= data_next;
         o_r_addr    <= r_addr_next;
      end
   end

   assign o_mem_en   = (state_reg == ST_WRITE);
   assign o_mem_addr = o_mem_en ? sq_addr[head_reg] : '0;
   assign o_mem_data = o_mem_en ? data_reg : '0;
   assign o_sq_empty = (count_reg == '0) && (state_reg == ST_IDLE);

endmodule

// File: tb/tb_retire_stage.sv
// Testbench for retire_stage: directed scenarios plus a randomized run scored against a
// queue-based model of the store queue and a next-cycle model of the register-write lanes.
module tb_retire_stage;

   localparam int PREG_W   = 6;
   localparam int SQ_DEPTH = 4;

   int n_checks = 0;
   int n_fail   = 0;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              ret_valid    [0:1];
   logic              ret_regwrite [0:1];
   logic              ret_memwrite [0:1];
   logic [PREG_W-1:0] ret_dst      [0:1];
   logic [31:0]       ret_data     [0:1];
   logic              ret_ready;
   logic              w_en         [0:1];
   logic [PREG_W-1:0] w_addr       [0:1];
   logic [31:0]       w_data       [0:1];
   logic              free_valid   [0:1];
   logic [PREG_W-1:0] free_preg    [0:1];
   logic [PREG_W-1:0] r_addr;
   logic [31:0]       r_data;
   logic              mem_en;
   logic [31:0]       mem_addr;
   logic [31:0]       mem_data;
   logic              sq_empty;
   logic [31:0]       retired_cnt;

   logic [31:0] rf [64];
   logic [31:0] exp_addr_q [$];
   logic [31:0] exp_data_q [$];

   always #5 clk = ~clk;

   retire_stage #(.PREG_W(PREG_W), .SQ_DEPTH(SQ_DEPTH)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_ret_valid(ret_valid), .i_ret_regwrite(ret_regwrite), .i_ret_memwrite(ret_memwrite),
      .i_ret_dst(ret_dst), .i_ret_data(ret_data),
      .o_ret_ready(ret_ready),
      .o_w_en(w_en), .o_w_addr(w_addr), .o_w_data(w_data),
      .o_free_valid(free_valid), .o_free_preg(free_preg),
      .o_r_addr(r_addr), .i_r_data(r_data),
      .o_mem_en(mem_en), .o_mem_addr(mem_addr), .o_mem_data(mem_data),
      .o_sq_empty(sq_empty), .o_retired_cnt(retired_cnt)
   );

   function automatic logic [31:0] init_val(input int k);
      return 32'hD000_0000 + 32'(k) * 32'h111;
   endfunction

   // Register file: synchronous read, data appears the cycle after the address.
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < 64; k++) rf[k] <= init_val(k);
      end else begin
         for (int l = 0; l < 2; l++) if (w_en[l]) rf[w_addr[l]] <= w_data[l];
      end
      r_data <= rf[r_addr];
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_lanes();
      for (int l = 0; l < 2; l++) begin
         ret_valid[l] = 1'b0; ret_regwrite[l] = 1'b0; ret_memwrite[l] = 1'b0;
         ret_dst[l] = '0; ret_data[l] = '0;
      end
   endtask

   task automatic set_lane(input int l, input bit rw, input bit mw, input logic [PREG_W-1:0] d,
                           input logic [31:0] v);
      ret_valid[l] = 1'b1; ret_regwrite[l] = rw; ret_memwrite[l] = mw;
      ret_dst[l] = d; ret_data[l] = v;
   endtask

   task automatic apply_reset();
      clear_lanes();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      clear_lanes();
      rst_n = 1'b0;
      #2;
      n_checks++; if (ret_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b want 1", ret_ready); end
      n_checks++; if (sq_empty !== 1'b1) begin n_fail++; $display("FAIL reset_sq_empty got %0b want 1", sq_empty); end
      n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en got %0b want 0", mem_en); end
      n_checks++; if (r_addr !== '0) begin n_fail++; $display("FAIL reset_r_addr got %0d want 0", r_addr); end
      n_checks++; if (retired_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_retired got %0d want 0", retired_cnt); end
      step();
      step();
      for (int l = 0; l < 2; l++) begin
         n_checks++; if (w_en[l] !== 1'b0) begin n_fail++; $display("FAIL reset_w_en%0d got %0b want 0", l, w_en[l]); end
         n_checks++; if (free_valid[l] !== 1'b0) begin n_fail++; $display("FAIL reset_free_valid%0d got %0b want 0", l, free_valid[l]); end
         n_checks++; if (w_addr[l] !== '0) begin n_fail++; $display("FAIL reset_w_addr%0d got %0d want 0", l, w_addr[l]); end
      end
      n_checks++; if (mem_addr !== 32'd0) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
      rst_n = 1'b1;
      $display("test_reset done");
   endtask

   task automatic test_alu_pair();
      clear_lanes();
      set_lane(0, 1, 0, 6'd5, 32'h1234);
      set_lane(1, 1, 0, 6'd9, 32'hABCD);
      n_checks++; if (ret_ready !== 1'b1) begin n_fail++; $display("FAIL alu_ready got %0b want 1", ret_ready); end
      step();
      clear_lanes();
      n_checks++; if (w_en[0] !== 1'b1 || w_en[1] !== 1'b1) begin n_fail++; $display("FAIL alu_w_en got %0b%0b want 11", w_en[0], w_en[1]); end
      n_checks++; if (w_addr[0] !== 6'd5 || w_addr[1] !== 6'd9) begin n_fail++; $display("FAIL alu_w_addr got %0d,%0d want 5,9", w_addr[0], w_addr[1]); end
      n_checks++; if (w_data[0] !== 32'h1234 || w_data[1] !== 32'hABCD) begin n_fail++; $display("FAIL alu_w_data got %h,%h want 1234,abcd", w_data[0], w_data[1]); end
      n_checks++; if (free_valid[0] !== 1'b1 || free_valid[1] !== 1'b1) begin n_fail++; $display("FAIL alu_free_valid got %0b%0b want 11", free_valid[0], free_valid[1]); end
      n_checks++; if (free_preg[0] !== 6'd5 || free_preg[1] !== 6'd9) begin n_fail++; $display("FAIL alu_free_preg got %0d,%0d want 5,9", free_preg[0], free_preg[1]); end
      n_checks++; if (retired_cnt !== 32'd2) begin n_fail++; $display("FAIL alu_retired got %0d want 2", retired_cnt); end
      step();
      n_checks++; if (w_en[0] !== 1'b0 || w_en[1] !== 1'b0) begin n_fail++; $display("FAIL alu_pulse_w_en got %0b%0b want 00", w_en[0], w_en[1]); end
      n_checks++; if (free_valid[0] !== 1'b0 || free_valid[1] !== 1'b0) begin n_fail++; $display("FAIL alu_pulse_free got %0b%0b want 00", free_valid[0], free_valid[1]); end
      n_checks++; if (retired_cnt !== 32'd2) begin n_fail++; $display("FAIL alu_retired_hold got %0d want 2", retired_cnt); end
      $display("test_alu_pair done");
   endtask

   task automatic test_single_store();
      clear_lanes();
      set_lane(0, 1, 0, 6'd3, 32'h55);
      step();
      clear_lanes();
      set_lane(0, 0, 1, 6'd3, 32'h40);
      step();
      clear_lanes();
      n_checks++; if (w_en[0] !== 1'b0 || free_valid[0] !== 1'b0) begin n_fail++; $display("FAIL store_no_wen got %0b/%0b want 0/0", w_en[0], free_valid[0]); end
      n_checks++; if (sq_empty !== 1'b0) begin n_fail++; $display("FAIL store_sq_busy got %0b want 0", sq_empty); end
      n_checks++; if (retired_cnt !== 32'd4) begin n_fail++; $display("FAIL store_retired got %0d want 4", retired_cnt); end
      step();
      n_checks++; if (r_addr !== 6'd3) begin n_fail++; $display("FAIL store_r_addr got %0d want 3", r_addr); end
      n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL store_early_mem_n2 got %0b want 0", mem_en); end
      step();
      n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL store_early_mem_n3 got %0b want 0", mem_en); end
      step();
      n_checks++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL store_mem_en got %0b want 1", mem_en); end
      n_checks++; if (mem_addr !== 32'h40) begin n_fail++; $display("FAIL store_mem_addr got %h want 40", mem_addr); end
      n_checks++; if (mem_data !== 32'h55) begin n_fail++; $display("FAIL store_mem_data got %h want 55", mem_data); end
      n_checks++; if (sq_empty !== 1'b0) begin n_fail++; $display("FAIL store_sq_busy_n4 got %0b want 0", sq_empty); end
      step();
      n_checks++; if (sq_empty !== 1'b1) begin n_fail++; $display("FAIL store_sq_empty got %0b want 1", sq_empty); end
      n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL store_mem_pulse got %0b want 0", mem_en); end
      $display("test_single_store done");
   endtask

   task automatic test_mixed_lanes();
      clear_lanes();
      set_lane(0, 0, 1, 6'd7, 32'h80);
      set_lane(1, 1, 0, 6'd7, 32'h77);
      step();
      clear_lanes();
      n_checks++; if (w_en[0] !== 1'b0 || w_en[1] !== 1'b1) begin n_fail++; $display("FAIL mixed_w_en got %0b%0b want 01", w_en[0], w_en[1]); end
      n_checks++; if (free_valid[0] !== 1'b0 || free_valid[1] !== 1'b1) begin n_fail++; $display("FAIL mixed_free got %0b%0b want 01", free_valid[0], free_valid[1]); end
      n_checks++; if (w_addr[1] !== 6'd7 || w_data[1] !== 32'h77) begin n_fail++; $display("FAIL mixed_w1 got %0d/%h want 7/77", w_addr[1], w_data[1]); end
      step();
      step();
      n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL mixed_early_mem got %0b want 0", mem_en); end
      step();
      n_checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h80) begin n_fail++; $display("FAIL mixed_mem got en=%0b addr=%h want en=1 addr=80", mem_en, mem_addr); end
      n_checks++; if (mem_data !== 32'h77) begin n_fail++; $display("FAIL mixed_mem_data got %h want 77", mem_data); end
      step();
      n_checks++; if (sq_empty !== 1'b1) begin n_fail++; $display("FAIL mixed_sq_empty got %0b want 1", sq_empty); end
      $display("test_mixed_lanes done");
   endtask

   task automatic test_queue_full();
      int  m_count = 0;
      int  pairs = 0;
      int  held = 0;
      int  n_mem = 0;
      int  cyc = 0;
      bit  pend;
      apply_reset();
      exp_addr_q.delete();
      exp_data_q.delete();
      while ((pairs < 3 || exp_addr_q.size() != 0) && cyc < 200) begin
         n_checks++; if (ret_ready !== (m_count <= SQ_DEPTH - 2)) begin n_fail++; $display("FAIL full_ready cyc=%0d got %0b want %0b", cyc, ret_ready, m_count <= SQ_DEPTH - 2); end
         pend = 1'b0;
         if (mem_en === 1'b1) begin
            pend = 1'b1;
            n_mem++;
            n_checks++;
            if (exp_addr_q.size() == 0) begin
               n_fail++; $display("FAIL full_mem_unexpected got addr=%h want none", mem_addr);
            end else begin
               if (mem_addr !== exp_addr_q[0] || mem_data !== exp_data_q[0]) begin
                  n_fail++; $display("FAIL full_mem_order got %h/%h want %h/%h", mem_addr, mem_data, exp_addr_q[0], exp_data_q[0]);
               end
               void'(exp_addr_q.pop_front());
               void'(exp_data_q.pop_front());
            end
         end
         clear_lanes();
         if (pairs < 3) begin
            set_lane(0, 0, 1, 6'(40 + 2 * pairs), 32'h100 + 32'(8 * pairs));
            set_lane(1, 0, 1, 6'(41 + 2 * pairs), 32'h104 + 32'(8 * pairs));
            if (ret_ready === 1'b1) begin
               exp_addr_q.push_back(32'h100 + 32'(8 * pairs)); exp_data_q.push_back(init_val(40 + 2 * pairs));
               exp_addr_q.push_back(32'h104 + 32'(8 * pairs)); exp_data_q.push_back(init_val(41 + 2 * pairs));
               m_count += 2;
               pairs++;
            end else if (pairs == 2) begin
               held++;
            end
         end
         if (pend) m_count--;
         step();
         cyc++;
      end
      clear_lanes();
      n_checks++; if (cyc >= 200) begin n_fail++; $display("FAIL full_timeout got %0d cycles want <200", cyc); end
      n_checks++; if (held == 0) begin n_fail++; $display("FAIL full_holdoff got %0d held cycles want >0", held); end
      n_checks++; if (n_mem != 6) begin n_fail++; $display("FAIL full_mem_count got %0d want 6", n_mem); end
      $display("test_queue_full done");
   endtask

   task automatic test_wrap();
      int  m_count = 0;
      int  pushed = 0;
      int  n_mem = 0;
      int  cyc = 0;
      bit  pend;
      apply_reset();
      exp_addr_q.delete();
      exp_data_q.delete();
      while ((pushed < 6 || exp_addr_q.size() != 0) && cyc < 200) begin
         n_checks++; if (ret_ready !== (m_count <= SQ_DEPTH - 2)) begin n_fail++; $display("FAIL wrap_ready cyc=%0d got %0b want %0b", cyc, ret_ready, m_count <= SQ_DEPTH - 2); end
         pend = 1'b0;
         if (mem_en === 1'b1) begin
            pend = 1'b1;
            n_mem++;
            n_checks++;
            if (exp_addr_q.size() == 0) begin
               n_fail++; $display("FAIL wrap_mem_unexpected got addr=%h want none", mem_addr);
            end else begin
               if (mem_addr !== exp_addr_q[0] || mem_data !== exp_data_q[0]) begin
                  n_fail++; $display("FAIL wrap_mem_order got %h/%h want %h/%h", mem_addr, mem_data, exp_addr_q[0], exp_data_q[0]);
               end
               void'(exp_addr_q.pop_front());
               void'(exp_data_q.pop_front());
            end
         end
         clear_lanes();
         if (pushed < 6) begin
            set_lane(0, 0, 1, 6'(32 + pushed), 32'h200 + 32'(4 * pushed));
            if (ret_ready === 1'b1) begin
               exp_addr_q.push_back(32'h200 + 32'(4 * pushed));
               exp_data_q.push_back(init_val(32 + pushed));
               m_count++;
               pushed++;
            end
         end
         if (pend) m_count--;
         step();
         cyc++;
      end
      clear_lanes();
      n_checks++; if (cyc >= 200) begin n_fail++; $display("FAIL wrap_timeout got %0d cycles want <200", cyc); end
      n_checks++; if (n_mem != 6) begin n_fail++; $display("FAIL wrap_mem_count got %0d want 6", n_mem); end
      n_checks++; if (sq_empty !== 1'b1) begin n_fail++; $display("FAIL wrap_sq_empty got %0b want 1", sq_empty); end
      $display("test_wrap done");
   endtask

   task automatic test_reset_drain();
      int mem_seen = 0;
      apply_reset();
      set_lane(0, 0, 1, 6'd50, 32'h300);
      set_lane(1, 0, 1, 6'd51, 32'h304);
      step();
      clear_lanes();
      step();
      n_checks++; if (r_addr !== 6'd50) begin n_fail++; $display("FAIL rdrain_in_read got r_addr=%0d want 50", r_addr); end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL rdrain_mem_en got %0b want 0", mem_en); end
      n_checks++; if (sq_empty !== 1'b1) begin n_fail++; $display("FAIL rdrain_sq_empty got %0b want 1", sq_empty); end
      n_checks++; if (ret_ready !== 1'b1) begin n_fail++; $display("FAIL rdrain_ready got %0b want 1", ret_ready); end
      n_checks++; if (r_addr !== '0) begin n_fail++; $display("FAIL rdrain_r_addr got %0d want 0", r_addr); end
      n_checks++; if (retired_cnt !== 32'd0) begin n_fail++; $display("FAIL rdrain_retired got %0d want 0", retired_cnt); end
      for (int i = 0; i < 14; i++) begin
         if (i == 2) rst_n = 1'b1;
         step();
         if (mem_en !== 1'b0) mem_seen++;
      end
      n_checks++; if (mem_seen != 0) begin n_fail++; $display("FAIL rdrain_no_mem got %0d pulses want 0", mem_seen); end
      n_checks++; if (sq_empty !== 1'b1) begin n_fail++; $display("FAIL rdrain_sq_empty_after got %0b want 1", sq_empty); end
      $display("test_reset_drain done");
   endtask

   task automatic test_random();
      int          m_count = 0;
      int          cyc = 0;
      int          n_mem = 0;
      int          kind;
      bit          pend;
      bit          acc;
      bit          exp_wen [2];
      logic [5:0]  exp_wa  [2];
      logic [31:0] exp_wd  [2];
      logic [31:0] exp_ret = 32'd0;
      apply_reset();
      exp_addr_q.delete();
      exp_data_q.delete();
      for (int l = 0; l < 2; l++) begin exp_wen[l] = 1'b0; exp_wa[l] = '0; exp_wd[l] = '0; end
      while ((cyc < 400 || exp_addr_q.size() != 0) && cyc < 1000) begin
         n_checks++; if (ret_ready !== (m_count <= SQ_DEPTH - 2)) begin n_fail++; $display("FAIL rand_ready cyc=%0d got %0b want %0b", cyc, ret_ready, m_count <= SQ_DEPTH - 2); end
         n_checks++; if (retired_cnt !== exp_ret) begin n_fail++; $display("FAIL rand_retired cyc=%0d got %0d want %0d", cyc, retired_cnt, exp_ret); end
         for (int l = 0; l < 2; l++) begin
            n_checks++; if (w_en[l] !== exp_wen[l] || free_valid[l] !== exp_wen[l]) begin n_fail++; $display("FAIL rand_wen%0d cyc=%0d got %0b/%0b want %0b", l, cyc, w_en[l], free_valid[l], exp_wen[l]); end
            if (exp_wen[l]) begin
               n_checks++;
               if (w_addr[l] !== exp_wa[l] || w_data[l] !== exp_wd[l] || free_preg[l] !== exp_wa[l]) begin
                  n_fail++; $display("FAIL rand_wport%0d cyc=%0d got %0d/%h/%0d want %0d/%h/%0d", l, cyc, w_addr[l], w_data[l], free_preg[l], exp_wa[l], exp_wd[l], exp_wa[l]);
               end
            end
         end
         pend = 1'b0;
         if (mem_en === 1'b1) begin
            pend = 1'b1;
            n_mem++;
            n_checks++;
            if (exp_addr_q.size() == 0) begin
               n_fail++; $display("FAIL rand_mem_unexpected got addr=%h want none", mem_addr);
            end else begin
               if (mem_addr !== exp_addr_q[0] || mem_data !== exp_data_q[0]) begin
                  n_fail++; $display("FAIL rand_mem_order got %h/%h want %h/%h", mem_addr, mem_data, exp_addr_q[0], exp_data_q[0]);
               end
               void'(exp_addr_q.pop_front());
               void'(exp_data_q.pop_front());
            end
         end
         clear_lanes();
         if (cyc < 400) begin
            for (int l = 0; l < 2; l++) begin
               if ($urandom_range(0, 3) != 0) begin
                  kind = $urandom_range(0, 4);
                  if (kind <= 1)      set_lane(l, 1, 0, 6'($urandom_range(0, 31)), $urandom);
                  else if (kind == 2) set_lane(l, 0, 1, 6'($urandom_range(32, 63)), $urandom);
                  else if (kind == 3) set_lane(l, 1, 1, 6'($urandom_range(32, 63)), $urandom);
                  else                set_lane(l, 0, 0, 6'($urandom_range(0, 63)), $urandom);
               end
            end
         end
         acc = (ret_ready === 1'b1);
         for (int l = 0; l < 2; l++) begin
            exp_wen[l] = acc && ret_valid[l] && ret_regwrite[l] && !ret_memwrite[l];
            if (exp_wen[l]) begin exp_wa[l] = ret_dst[l]; exp_wd[l] = ret_data[l]; end
            if (acc && ret_valid[l]) exp_ret = exp_ret + 32'd1;
            if (acc && ret_valid[l] && ret_memwrite[l]) begin
               exp_addr_q.push_back(ret_data[l]);
               exp_data_q.push_back(init_val(int'(ret_dst[l])));
               m_count++;
            end
         end
         if (pend) m_count--;
         step();
         cyc++;
      end
      clear_lanes();
      n_checks++; if (cyc >= 1000) begin n_fail++; $display("FAIL rand_timeout got %0d cycles want <1000", cyc); end
      $display("test_random done: %0d cycles, %0d memory writes", cyc, n_mem);
   endtask

   initial begin
      test_reset();
      test_alu_pair();
      test_single_store();
      test_mixed_lanes();
      test_queue_full();
      test_wrap();
      test_reset_drain();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/retire_stage.md
RETIRE_STAGE -- requirements
Module: retire_stage

Interface
REQ-001 Parameter PREG_W, default 6: physical register address width.
REQ-002 Parameter SQ_DEPTH, default 4, power of two and at least 2: store-queue entry count.
REQ-003 Port i_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port i_rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Ports i_ret_valid[0:1], input, 1 each: retiring ROB row valid per lane; lane 0 is older.
REQ-006 Ports i_ret_regwrite[0:1] and i_ret_memwrite[0:1], input, 1 each: row writes a register, or row is a store.
REQ-007 Ports i_ret_dst[0:1], input, PREG_W each: destination preg; for stores, the preg holding the store data.
REQ-008 Ports i_ret_data[0:1], input, 32 each: FU result; for stores, the memory address.
REQ-009 Port o_ret_ready, output, 1: retire rows are accepted this cycle.
REQ-010 Ports o_w_en[0:1], o_w_addr[0:1] (PREG_W) and o_w_data[0:1] (32), output: register-file write port per lane.
REQ-011 Ports o_free_valid[0:1] and o_free_preg[0:1] (PREG_W), output: freed-preg notification to rename.
REQ-012 Port o_r_addr, output, PREG_W: register-file read address for store data.
REQ-013 Port i_r_data, input, 32: read data, valid the cycle after o_r_addr changes.
REQ-014 Ports o_mem_en (1), o_mem_addr (32) and o_mem_data (32), output: memory write port.
REQ-015 Ports o_sq_empty (1) and o_retired_cnt (32), output: store queue empty; total accepted rows.

Function
REQ-016 The block SHALL accept retiring rows in a cycle when o_ret_ready=1; rows presented while o_ret_ready=0 are ignored.
REQ-017 o_ret_ready SHALL be 1 exactly when at least 2 store-queue slots are free, computed combinationally from the registered count.
REQ-018 For an accepted lane with valid=1, regwrite=1 and memwrite=0, the next cycle SHALL drive o_w_en=1, o_w_addr=dst and o_w_data=data on that lane.
REQ-019 For the same row, the next cycle SHALL also drive o_free_valid=1 and o_free_preg=dst on that lane.
REQ-020 For an accepted lane with valid=1 and memwrite=1, the block SHALL push {addr=data, preg=dst} into the store queue.
REQ-021 When both lanes are stores, lane 0 SHALL be pushed first so that lane 0 drains first.
REQ-022 A store row SHALL assert no o_w_en and no o_free_valid.
REQ-023 A lane that is not accepted or not valid SHALL produce o_w_en=0 and o_free_valid=0 in the following cycle; these outputs are single-cycle pulses.
REQ-024 A row with memwrite=1 and regwrite=1 SHALL be treated as a store only.
REQ-025 The store queue SHALL be a circular FIFO with head and tail pointers that wrap modulo SQ_DEPTH and a count of 0..SQ_DEPTH.
REQ-026 On a simultaneous push and pop, the count SHALL become count + pushes - pop, with no overflow and no loss.
REQ-027 The drain FSM SHALL use three states: IDLE, READ and WRITE.
REQ-028 IDLE: if count>0, register o_r_addr=head.preg and go to READ; otherwise stay in IDLE.
REQ-029 READ: capture i_r_data into a data register and go to WRITE.
REQ-030 WRITE: for exactly one cycle drive o_mem_en=1, o_mem_addr=head.addr and o_mem_data=captured data, and pop the head.
REQ-031 From WRITE, the FSM SHALL go to READ with o_r_addr=the next head's preg when count after the pop is >0, and to IDLE otherwise.
REQ-032 A store pushed in cycle N SHALL NOT reach READ before cycle N+2, so any same-cycle register write has landed first.
REQ-033 o_mem_en SHALL be 0 in every state other than WRITE.
REQ-034 o_sq_empty SHALL equal (count==0 and state==IDLE).
REQ-035 o_retired_cnt SHALL add the number of accepted valid lanes (0, 1 or 2) each cycle and wrap modulo 2^32.

Reset
REQ-036 Asserting i_rst_n=0 SHALL immediately clear the FIFO pointers and count, the FSM (to IDLE), o_w_en, o_free_valid, o_mem_en, o_r_addr, o_mem_addr, o_mem_data, o_w_addr, o_w_data, o_free_preg and o_retired_cnt to 0, and set o_sq_empty=1.
REQ-037 While i_rst_n=0, o_ret_ready SHALL read 1.
REQ-038 A store queued or in flight when reset is asserted SHALL be discarded, with no o_mem_en pulse.
REQ-039 After deassertion, the first rising edge SHALL resume normal operation.

Verification
REQ-040 Lane0 ALU {dst=5, data=0x1234} and lane1 ALU {dst=9, data=0xABCD} accepted at cycle N -> at N+1, o_w_en={1,1}, o_w_addr={5,9}, o_w_data={0x1234,0xABCD}, o_free_preg={5,9}; o_retired_cnt=2.
REQ-041 Single store {dst=3, addr=0x40} accepted at N, reg3 holding 0x55 -> o_r_addr=3 at N+2, o_mem_en=1 at N+4 with o_mem_addr=0x40 and o_mem_data=0x55, o_sq_empty=1 at N+5.
REQ-042 Two store pairs on consecutive cycles with SQ_DEPTH=4 -> o_ret_ready=0 while count>2; drain order addr0, addr1, addr2, addr3; a third pair held off is accepted once count<=2.
REQ-043 Six stores pushed while draining -> pointers wrap past SQ_DEPTH, writes occur in push order, and the count never exceeds 4.
REQ-044 Drive i_rst_n=0 in READ with 2 queued stores -> outputs clear without a clock edge, no o_mem_en pulse follows, and o_sq_empty=1.
REQ-045 Lane0 store and lane1 ALU write in the same cycle -> the register write appears at N+1 and the memory write at N+4; o_free_valid={0,1}.
